// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer: FETCH -> EXEC (-> MEMWAIT) -> FETCH until halt.
// Define PERF_COUNT_EN to include the 16-bit retired-instruction counter; otherwise instr_count is tied to 0.
module fetch_sequencer #(
  parameter int PCW      = 10,
  parameter int START_PC = 0,
  parameter int MEM_WAIT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           halt,
  input  logic           branch,
  input  logic           taken,
  input  logic [PCW-1:0] target,
  input  logic           mem_read,
  input  logic           mem_write,
  output logic [PCW-1:0] pc,
  output logic           ir_load,
  output logic           reg_we_gate,
  output logic           mem_we_gate,
  output logic           busy,
  output logic           done,
  output logic [15:0]    instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEMWAIT,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [PCW-1:0] r_pc;
  logic [1:0]     r_wait;
  logic           w_load;
  logic           w_retire;
  logic           w_wait_last;

  // For MEM_WAIT=0 the compare value is never reached because MEMWAIT is never entered.
  assign w_wait_last = (r_wait == 2'(MEM_WAIT - 1));

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_retire    = 1'b0;
    ir_load     = 1'b0;
    reg_we_gate = 1'b0;
    mem_we_gate = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_load = 1'b1;
        w_next  = S_EXEC;
      end
      S_EXEC: begin
        if (halt) begin
          w_next = S_DONE;
        end else if (mem_read && (MEM_WAIT > 0)) begin
          w_next = S_MEMWAIT;
        end else begin
          reg_we_gate = 1'b1;
          mem_we_gate = mem_write;
          w_retire    = 1'b1;
          w_next      = S_FETCH;
        end
      end
      S_MEMWAIT: begin
        if (w_wait_last) begin
          reg_we_gate = 1'b1;
          w_retire    = 1'b1;
          w_next      = S_FETCH;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= PCW'(START_PC);
      r_wait  <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_pc <= PCW'(START_PC);
      end else if (w_retire) begin
        r_pc <= (branch && taken) ? target : r_pc + PCW'(1);
      end
      if (r_state == S_EXEC) begin
        r_wait <= 2'd0;
      end else if (r_state == S_MEMWAIT) begin
        r_wait <= r_wait + 2'd1;
      end
    end
  end

`ifdef PERF_COUNT_EN
  logic [15:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || w_load) begin
      r_count <= 16'd0;
    end else if (w_retire) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign instr_count = r_count;
`else
  assign instr_count = 16'd0;
`endif

  assign pc   = r_pc;
  assign busy = (r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_MEMWAIT);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer (PCW=10, START_PC=0, MEM_WAIT=2).
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, halt, branch, taken, mem_read, mem_write;
  logic [9:0]  target;
  logic [9:0]  pc;
  logic        ir_load, reg_we_gate, mem_we_gate, busy, done;
  logic [15:0] instr_count;

  int checks   = 0;
  int failures = 0;

  fetch_sequencer #(.PCW(10), .START_PC(0), .MEM_WAIT(2)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .branch(branch),
    .taken(taken), .target(target), .mem_read(mem_read), .mem_write(mem_write),
    .pc(pc), .ir_load(ir_load), .reg_we_gate(reg_we_gate), .mem_we_gate(mem_we_gate),
    .busy(busy), .done(done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ecnt(input int n);
`ifdef PERF_COUNT_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  task automatic clr();
    start = 0; halt = 0; branch = 0; taken = 0; mem_read = 0; mem_write = 0; target = '0;
  endtask

  // From FETCH, run one EXEC with a taken branch to dst, ending in FETCH at dst.
  task automatic jump(input logic [9:0] dst);
    tick();
    branch = 1; taken = 1; target = dst;
    tick();
    clr();
  endtask

  initial begin
    clr();
    reset = 1;
    tick(); tick();
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_irload", ir_load, 0);
    check("rst_cnt", instr_count, ecnt(0));

    // Start on the first edge after reset release
    reset = 0; start = 1;
    tick();
    start = 0;
    check("start_fetch_irload", ir_load, 1);
    check("start_busy", busy, 1);
    check("start_pc", pc, 0);

    // Three plain instructions, then halt at pc=3
    for (int i = 0; i < 3; i++) begin
      tick();
      check("exec_irload", ir_load, 0);
      check("exec_regwe", reg_we_gate, 1);
      check("exec_memwe", mem_we_gate, 0);
      tick();
      check("seq_pc", pc, 32'(i + 1));
      check("seq_irload", ir_load, 1);
    end
    tick();
    halt = 1; #1;
    check("halt_regwe", reg_we_gate, 0);
    tick();
    halt = 0;
    check("halt_done", done, 1);
    check("halt_busy", busy, 0);
    check("halt_pc", pc, 3);
    check("halt_cnt", instr_count, ecnt(3));

    // Restart from DONE; start held while busy must not disturb pc
    start = 1;
    tick();
    check("restart_pc", pc, 0);
    check("restart_cnt", instr_count, ecnt(0));
    tick();
    tick();
    start = 0;
    check("busy_start_pc", pc, 1);
    check("busy_start_irload", ir_load, 1);

    // Branch taken / not taken at pc=5
    jump(10'd5);
    check("br_to5", pc, 5);
    jump(10'h2A);
    check("br_taken", pc, 10'h2A);
    jump(10'd5);
    tick();
    branch = 1; taken = 0; target = 10'h2A;
    tick();
    clr();
    check("br_not_taken", pc, 6);

    // Load at pc=4 with two wait cycles
    jump(10'd4);
    tick();
    mem_read = 1; #1;
    check("ld_exec_regwe", reg_we_gate, 0);
    check("ld_exec_memwe", mem_we_gate, 0);
    tick();
    check("ld_mw1_regwe", reg_we_gate, 0);
    check("ld_mw1_busy", busy, 1);
    check("ld_mw1_pc", pc, 4);
    tick();
    check("ld_mw2_regwe", reg_we_gate, 1);
    check("ld_mw2_pc", pc, 4);
    tick();
    mem_read = 0;
    check("ld_next_pc", pc, 5);
    check("ld_next_irload", ir_load, 1);

    // PC wrap and a store
    jump(10'h3FF);
    tick();
    mem_write = 1; #1;
    check("sb_memwe", mem_we_gate, 1);
    check("sb_regwe", reg_we_gate, 1);
    tick();
    check("wrap_pc", pc, 0);
    check("sb_fetch_memwe", mem_we_gate, 0);
    mem_write = 0;
    tick();
    tick();
    check("post_wrap_pc", pc, 1);

    // Halt beats branch and store
    tick();
    halt = 1; branch = 1; taken = 1; target = 10'h155; mem_write = 1; #1;
    check("hp_memwe", mem_we_gate, 0);
    check("hp_regwe", reg_we_gate, 0);
    tick();
    clr();
    check("hp_done", done, 1);
    check("hp_pc", pc, 1);
    check("hp_cnt", instr_count, ecnt(10));
    start = 1;
    tick();
    start = 0;
    check("hp_restart_pc", pc, 0);
    check("hp_restart_cnt", instr_count, ecnt(0));

    // Reset in MEMWAIT
    tick();
    tick();
    check("pre_ld_pc", pc, 1);
    tick();
    mem_read = 1;
    tick();
    reset = 1;
    tick();
    check("rmw_pc", pc, 0);
    check("rmw_busy", busy, 0);
    check("rmw_done", done, 0);
    check("rmw_irload", ir_load, 0);
    check("rmw_regwe", reg_we_gate, 0);
    check("rmw_memwe", mem_we_gate, 0);
    check("rmw_cnt", instr_count, ecnt(0));
    reset = 0; mem_read = 0;
    tick();
    check("idle_stays", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter PCW, default 10, program counter width in bits.
REQ-002 SHALL have parameter START_PC, default 0, PC loaded on start.
REQ-003 SHALL have parameter MEM_WAIT, default 1, extra load wait cycles, legal range 0..3.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin program execution at START_PC.
REQ-007 SHALL have port halt  input  1  decoded instruction is halt.
REQ-008 SHALL have port branch  input  1  decoder Branch output.
REQ-009 SHALL have port taken  input  1  ALU branch condition true.
REQ-010 SHALL have port target  input  PCW  branch target address.
REQ-011 SHALL have port mem_read  input  1  decoder MemRead output.
REQ-012 SHALL have port mem_write  input  1  decoder MemWrite output.
REQ-013 SHALL have port pc  output  PCW  current instruction address.
REQ-014 SHALL have port ir_load  output  1  latch the instruction register this cycle.
REQ-015 SHALL have port reg_we_gate  output  1  qualifies decoder RegWrite.
REQ-016 SHALL have port mem_we_gate  output  1  data memory write strobe.
REQ-017 SHALL have port busy  output  1  program running.
REQ-018 SHALL have port done  output  1  program halted.
REQ-019 SHALL have port instr_count  output  16  retired instruction count.

Function
REQ-020 SHALL implement FSM states IDLE, FETCH, EXEC, MEMWAIT, DONE.
REQ-021 IDLE: start=1 SHALL load pc=START_PC, clear instr_count, and go to FETCH; otherwise SHALL remain in IDLE.
REQ-022 FETCH: ir_load SHALL be 1 for exactly one cycle, next state EXEC.
REQ-023 EXEC with halt=1 SHALL go to DONE with no gate asserted, pc held, count unchanged; halt SHALL take priority over branch, mem_read and mem_write.
REQ-024 EXEC with mem_read=1 and MEM_WAIT>0 SHALL go to MEMWAIT with no gate asserted.
REQ-025 MEMWAIT SHALL last exactly MEM_WAIT cycles; in its last cycle it SHALL assert reg_we_gate, retire the instruction and go to FETCH.
REQ-026 All other EXEC cases SHALL assert reg_we_gate=1 and mem_we_gate=mem_write, retire the instruction, and go to FETCH.
REQ-027 Retire SHALL set pc=target if branch&&taken, else pc+1 modulo 2^PCW (wrap to 0 from 2^PCW-1); it SHALL also increment instr_count.
REQ-028 Latency SHALL be 2 cycles per instruction, and 2+MEM_WAIT cycles for loads.
REQ-029 busy SHALL be 1 in FETCH, EXEC and MEMWAIT, otherwise 0.
REQ-030 done SHALL be 1 only in DONE; start=1 in DONE SHALL restart exactly as in IDLE.
REQ-031 start SHALL be ignored while busy=1.
REQ-032 mem_we_gate SHALL never be asserted outside EXEC, and SHALL never be asserted together with halt.

Reset
REQ-033 reset=1 at a clock edge SHALL force state IDLE, pc=START_PC, instr_count=0 and all 1-bit outputs to 0, overriding every other input, including mid-instruction and in MEMWAIT.
REQ-034 On the first edge after reset deasserts, the block SHALL respond to start.

Configuration
REQ-035 Macro PERF_COUNT_EN defined: instr_count SHALL be a 16-bit counter per REQ-021/027 that wraps 0xFFFF->0x0000.
REQ-036 Macro PERF_COUNT_EN undefined: the counter SHALL be absent and instr_count SHALL be constant 0.

Verification
REQ-037 reset, then a start pulse, then 3 non-memory instructions then halt -> pc 0,1,2,3; ir_load every 2nd cycle; done=1 with pc=3, instr_count=3.
REQ-038 branch=1, taken=1, target=0x2A at pc=5 -> next pc=0x2A; same with taken=0 -> next pc=6.
REQ-039 MEM_WAIT=2, lb at pc=4 -> reg_we_gate low for 2 cycles, high once in the 2nd MEMWAIT cycle; next FETCH at pc=5 after 4 cycles total.
REQ-040 pc=0x3FF (PCW=10), non-branch retire -> pc=0x000; sb instruction -> mem_we_gate=1 for exactly one cycle.
REQ-041 reset asserted in MEMWAIT -> next cycle IDLE, pc=START_PC, all outputs 0; start while busy -> no effect on pc.
REQ-042 halt=1 with branch=1, taken=1, mem_write=1 -> DONE, mem_we_gate=0, pc unchanged; start in DONE -> pc=START_PC, instr_count=0.
